// File: rtl/control_pkg.sv
// Shared encodings for the multi-cycle RISC-V control FSM.
// RV_JAL_EN adds the JAL state; without it the JAL opcode decodes as illegal.
package control_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [3:0] {
        ST_RESET     = 4'd0,
        ST_FETCH     = 4'd1,
        ST_DECODE    = 4'd2,
        ST_MEM_ADDR  = 4'd3,
        ST_MEM_READ  = 4'd4,
        ST_MEM_WB    = 4'd5,
        ST_MEM_WRITE = 4'd6,
        ST_EXEC_R    = 4'd7,
        ST_EXEC_I    = 4'd8,
        ST_ALU_WB    = 4'd9,
        ST_BRANCH    = 4'd10,
`ifdef RV_JAL_EN
        ST_JAL       = 4'd11,
`endif
        ST_TRAP      = 4'd12
    } state_e;

    typedef enum logic [2:0] {
        CLS_R       = 3'd0,
        CLS_I       = 3'd1,
        CLS_LOAD    = 3'd2,
        CLS_STORE   = 3'd3,
        CLS_BRANCH  = 3'd4,
        CLS_JAL     = 3'd5,
        CLS_ILLEGAL = 3'd6
    } op_class_e;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_RTYPE = 2'b10;
    localparam logic [1:0] ALU_ITYPE = 2'b11;

    localparam logic [1:0] M2R_ALU = 2'b00;
    localparam logic [1:0] M2R_MDR = 2'b01;
    localparam logic [1:0] M2R_PC4 = 2'b10;

    localparam logic [1:0] PCS_ALU    = 2'b00;
    localparam logic [1:0] PCS_ALUOUT = 2'b01;
    localparam logic [1:0] PCS_JUMP   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;

    // States that own the memory port and may stall on mem_ready.
    function automatic logic is_wait_state(input state_e s);
        return (s == ST_FETCH) || (s == ST_MEM_READ) || (s == ST_MEM_WRITE);
    endfunction

endpackage

// File: rtl/opcode_class.sv
// Combinational opcode-to-class decode used by the DECODE dispatch.
// RV_JAL_EN controls whether the JAL opcode is a legal class.
module opcode_class
    import control_pkg::*;
(
    input  logic [6:0] opcode,
    output logic [2:0] op_class
);

    always_comb begin
        op_class = CLS_ILLEGAL;
        case (opcode)
            OP_R:      op_class = CLS_R;
            OP_I:      op_class = CLS_I;
            OP_LOAD:   op_class = CLS_LOAD;
            OP_STORE:  op_class = CLS_STORE;
            OP_BRANCH: op_class = CLS_BRANCH;
`ifdef RV_JAL_EN
            OP_JAL:    op_class = CLS_JAL;
`endif
            default:   op_class = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle RISC-V control FSM with memory ready handshake and wait timeout.
// RV_JAL_EN enables the JAL state.
module multicycle_control
    import control_pkg::*;
#(
    parameter int WAIT_MAX = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       ir_write,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       reg_write,
    output logic [1:0] mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic [3:0] state,
    output logic       illegal,
    output logic       fault
);

    localparam int CW = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = (WAIT_MAX > 0) ? CW'(WAIT_MAX - 1) : '0;

    state_e        state_reg, state_next;
    logic [CW-1:0] cnt_reg;
    logic          illegal_reg, fault_reg;
    logic          set_illegal, set_fault;
    logic          wait_expired;
    logic [2:0]    cls_raw;
    op_class_e     cls;

    opcode_class u_opcode_class (
        .opcode   (opcode),
        .op_class (cls_raw)
    );

    assign cls = op_class_e'(cls_raw);
    // A ready in the final allowed wait cycle still completes the access.
    assign wait_expired = (WAIT_MAX != 0) && (cnt_reg == CNT_LAST) && !mem_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_RESET;
            cnt_reg     <= '0;
            illegal_reg <= 1'b0;
            fault_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (state_next != state_reg)
                cnt_reg <= '0;
            else if (is_wait_state(state_reg) && !mem_ready)
                cnt_reg <= cnt_reg + 1'b1;
            if (set_illegal)
                illegal_reg <= 1'b1;
            if (set_fault)
                fault_reg <= 1'b1;
        end
    end

    always_comb begin
        state_next  = state_reg;
        set_illegal = 1'b0;
        set_fault   = 1'b0;
        pc_write    = 1'b0;
        ir_write    = 1'b0;
        iord        = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        reg_write   = 1'b0;
        mem_to_reg  = M2R_ALU;
        alu_src_a   = 1'b0;
        alu_src_b   = SRCB_RS2;
        alu_op      = ALU_ADD;
        pc_source   = PCS_ALU;
        case (state_reg)
            ST_RESET: state_next = ST_FETCH;
            ST_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                if (mem_ready) begin
                    state_next = ST_DECODE;
                end else if (wait_expired) begin
                    state_next = ST_TRAP;
                    set_fault  = 1'b1;
                end
            end
            ST_DECODE: begin
                alu_src_b = SRCB_IMM;
                case (cls)
                    CLS_R:               state_next = ST_EXEC_R;
                    CLS_I:               state_next = ST_EXEC_I;
                    CLS_LOAD, CLS_STORE: state_next = ST_MEM_ADDR;
                    CLS_BRANCH:          state_next = ST_BRANCH;
`ifdef RV_JAL_EN
                    CLS_JAL:             state_next = ST_JAL;
`endif
                    default: begin
                        state_next  = ST_TRAP;
                        set_illegal = 1'b1;
                    end
                endcase
            end
            ST_MEM_ADDR: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_IMM;
                state_next = (cls == CLS_STORE) ? ST_MEM_WRITE : ST_MEM_READ;
            end
            ST_MEM_READ: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                if (mem_ready) begin
                    state_next = ST_MEM_WB;
                end else if (wait_expired) begin
                    state_next = ST_TRAP;
                    set_fault  = 1'b1;
                end
            end
            ST_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = M2R_MDR;
                state_next = ST_FETCH;
            end
            ST_MEM_WRITE: begin
                mem_write = 1'b1;
                iord      = 1'b1;
                if (mem_ready) begin
                    state_next = ST_FETCH;
                end else if (wait_expired) begin
                    state_next = ST_TRAP;
                    set_fault  = 1'b1;
                end
            end
            ST_EXEC_R: begin
                alu_src_a  = 1'b1;
                alu_op     = ALU_RTYPE;
                state_next = ST_ALU_WB;
            end
            ST_EXEC_I: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_IMM;
                alu_op     = ALU_ITYPE;
                state_next = ST_ALU_WB;
            end
            ST_ALU_WB: begin
                reg_write  = 1'b1;
                state_next = ST_FETCH;
            end
            ST_BRANCH: begin
                alu_src_a  = 1'b1;
                alu_op     = ALU_SUB;
                pc_source  = PCS_ALUOUT;
                pc_write   = zero;
                state_next = ST_FETCH;
            end
`ifdef RV_JAL_EN
            ST_JAL: begin
                pc_source  = PCS_JUMP;
                pc_write   = 1'b1;
                reg_write  = 1'b1;
                mem_to_reg = M2R_PC4;
                state_next = ST_FETCH;
            end
`endif
            ST_TRAP: state_next = ST_TRAP;
            default: state_next = ST_RESET;
        endcase
    end

    assign state   = state_reg;
    assign illegal = illegal_reg;
    assign fault   = fault_reg;

endmodule

// File: tb/tb_multicycle_control.sv
// Table-driven bench for multicycle_control, plus directed timeout/trap/reset sequences.
module tb_multicycle_control;
    import control_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] opcode = 7'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       pc_write, ir_write, iord, mem_read, mem_write, reg_write;
    logic [1:0] mem_to_reg, alu_src_b, alu_op, pc_source;
    logic       alu_src_a, illegal, fault;
    logic [3:0] state;
    logic [14:0] act_ctl;

    int total = 0;
    int bad = 0;

    multicycle_control #(.WAIT_MAX(4)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .ir_write(ir_write), .iord(iord), .mem_read(mem_read),
        .mem_write(mem_write), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_source(pc_source), .state(state), .illegal(illegal), .fault(fault)
    );

    always #5 clk = ~clk;

    assign act_ctl = {pc_write, ir_write, iord, mem_read, mem_write, reg_write,
                      mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source};

    typedef struct {
        logic       rdy;
        logic [6:0] opc;
        logic       z;
        logic [3:0] st;
        logic [14:0] ctl;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [14:0] ctl(input logic pcw, input logic irw, input logic io,
                                        input logic mr, input logic mw, input logic rw,
                                        input logic [1:0] m2r, input logic sa,
                                        input logic [1:0] sb, input logic [1:0] aop,
                                        input logic [1:0] ps);
        return {pcw, irw, io, mr, mw, rw, m2r, sa, sb, aop, ps};
    endfunction

    logic [14:0] c_frdy, c_fwait, c_dec, c_exr, c_exi, c_awb, c_mad, c_mrd, c_mwb, c_mwr;
    logic [14:0] c_br1, c_br0, c_jal, c_none;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_all(input string name, input logic [3:0] st, input logic [14:0] c,
                              input logic ill, input logic flt);
        check({name, " state"}, 32'(state), 32'(st));
        check({name, " ctl"}, 32'(act_ctl), 32'(c));
        check({name, " illegal"}, 32'(illegal), 32'(ill));
        check({name, " fault"}, 32'(fault), 32'(flt));
        $display("txn %s: state=%0d ctl=%h illegal=%0b fault=%0b", name, state, act_ctl, illegal, fault);
    endtask

    task automatic cyc(input logic rdy, input logic [6:0] opc, input logic z);
        @(negedge clk);
        mem_ready = rdy;
        opcode    = opc;
        zero      = z;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        expect_all("reset", 4'(ST_RESET), c_none, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic add(input logic rdy, input logic [6:0] opc, input logic z,
                       input state_e st, input logic [14:0] c);
        vecs.push_back('{rdy, opc, z, 4'(st), c});
    endtask

    initial begin
        c_frdy  = ctl(1, 1, 0, 1, 0, 0, 2'b00, 0, 2'b01, 2'b00, 2'b00);
        c_fwait = ctl(0, 0, 0, 1, 0, 0, 2'b00, 0, 2'b01, 2'b00, 2'b00);
        c_dec   = ctl(0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b10, 2'b00, 2'b00);
        c_exr   = ctl(0, 0, 0, 0, 0, 0, 2'b00, 1, 2'b00, 2'b10, 2'b00);
        c_exi   = ctl(0, 0, 0, 0, 0, 0, 2'b00, 1, 2'b10, 2'b11, 2'b00);
        c_awb   = ctl(0, 0, 0, 0, 0, 1, 2'b00, 0, 2'b00, 2'b00, 2'b00);
        c_mad   = ctl(0, 0, 0, 0, 0, 0, 2'b00, 1, 2'b10, 2'b00, 2'b00);
        c_mrd   = ctl(0, 0, 1, 1, 0, 0, 2'b00, 0, 2'b00, 2'b00, 2'b00);
        c_mwb   = ctl(0, 0, 0, 0, 0, 1, 2'b01, 0, 2'b00, 2'b00, 2'b00);
        c_mwr   = ctl(0, 0, 1, 0, 1, 0, 2'b00, 0, 2'b00, 2'b00, 2'b00);
        c_br1   = ctl(1, 0, 0, 0, 0, 0, 2'b00, 1, 2'b00, 2'b01, 2'b01);
        c_br0   = ctl(0, 0, 0, 0, 0, 0, 2'b00, 1, 2'b00, 2'b01, 2'b01);
        c_jal   = ctl(1, 0, 0, 0, 0, 1, 2'b10, 0, 2'b00, 2'b00, 2'b10);
        c_none  = '0;

        // R-type, zero-wait: 4 cycles
        add(1, OP_R, 0, ST_FETCH, c_frdy);   add(1, OP_R, 0, ST_DECODE, c_dec);
        add(1, OP_R, 0, ST_EXEC_R, c_exr);   add(1, OP_R, 0, ST_ALU_WB, c_awb);
        // load, read ready delayed 2 cycles: 7 cycles
        add(1, OP_LOAD, 0, ST_FETCH, c_frdy);    add(1, OP_LOAD, 0, ST_DECODE, c_dec);
        add(1, OP_LOAD, 0, ST_MEM_ADDR, c_mad);  add(0, OP_LOAD, 0, ST_MEM_READ, c_mrd);
        add(0, OP_LOAD, 0, ST_MEM_READ, c_mrd);  add(1, OP_LOAD, 0, ST_MEM_READ, c_mrd);
        add(1, OP_LOAD, 0, ST_MEM_WB, c_mwb);
        // store, zero-wait: 4 cycles
        add(1, OP_STORE, 0, ST_FETCH, c_frdy);   add(1, OP_STORE, 0, ST_DECODE, c_dec);
        add(1, OP_STORE, 0, ST_MEM_ADDR, c_mad); add(1, OP_STORE, 0, ST_MEM_WRITE, c_mwr);
        // store with 3 waits in each memory state; counter restarts per state
        add(0, OP_STORE, 0, ST_FETCH, c_fwait);  add(0, OP_STORE, 0, ST_FETCH, c_fwait);
        add(0, OP_STORE, 0, ST_FETCH, c_fwait);  add(1, OP_STORE, 0, ST_FETCH, c_frdy);
        add(1, OP_STORE, 0, ST_DECODE, c_dec);   add(1, OP_STORE, 0, ST_MEM_ADDR, c_mad);
        add(0, OP_STORE, 0, ST_MEM_WRITE, c_mwr); add(0, OP_STORE, 0, ST_MEM_WRITE, c_mwr);
        add(0, OP_STORE, 0, ST_MEM_WRITE, c_mwr); add(1, OP_STORE, 0, ST_MEM_WRITE, c_mwr);
        // I-type
        add(1, OP_I, 0, ST_FETCH, c_frdy);   add(1, OP_I, 0, ST_DECODE, c_dec);
        add(1, OP_I, 0, ST_EXEC_I, c_exi);   add(1, OP_I, 0, ST_ALU_WB, c_awb);
        // beq taken, then not taken
        add(1, OP_BRANCH, 1, ST_FETCH, c_frdy); add(1, OP_BRANCH, 1, ST_DECODE, c_dec);
        add(1, OP_BRANCH, 1, ST_BRANCH, c_br1);
        add(1, OP_BRANCH, 0, ST_FETCH, c_frdy); add(1, OP_BRANCH, 0, ST_DECODE, c_dec);
        add(1, OP_BRANCH, 0, ST_BRANCH, c_br0);

        repeat (2) @(negedge clk);
        expect_all("por", 4'(ST_RESET), c_none, 1'b0, 1'b0);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            cyc(vecs[i].rdy, vecs[i].opc, vecs[i].z);
            expect_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].ctl, 1'b0, 1'b0);
        end

        // Timeout: four waits in FETCH, then sticky TRAP with fault.
        for (int i = 0; i < 4; i++) begin
            cyc(0, OP_R, 0);
            expect_all($sformatf("to_wait%0d", i), 4'(ST_FETCH), c_fwait, 1'b0, 1'b0);
        end
        cyc(1, OP_R, 0);
        expect_all("to_trap", 4'(ST_TRAP), c_none, 1'b0, 1'b1);
        cyc(1, OP_R, 0);
        expect_all("to_hold", 4'(ST_TRAP), c_none, 1'b0, 1'b1);
        do_reset();

        // Ready on the 4th wait-limited cycle still completes the fetch.
        for (int i = 0; i < 3; i++) begin
            cyc(0, OP_R, 0);
            expect_all($sformatf("late_wait%0d", i), 4'(ST_FETCH), c_fwait, 1'b0, 1'b0);
        end
        cyc(1, OP_R, 0);
        expect_all("late_rdy", 4'(ST_FETCH), c_frdy, 1'b0, 1'b0);
        cyc(1, OP_R, 0);
        expect_all("late_dec", 4'(ST_DECODE), c_dec, 1'b0, 1'b0);
        cyc(1, OP_R, 0);
        expect_all("late_exr", 4'(ST_EXEC_R), c_exr, 1'b0, 1'b0);
        cyc(1, OP_R, 0);
        expect_all("late_wb", 4'(ST_ALU_WB), c_awb, 1'b0, 1'b0);

        // Illegal opcode: TRAP held with no strobes until reset.
        cyc(1, 7'b1111111, 0);
        expect_all("ill_fetch", 4'(ST_FETCH), c_frdy, 1'b0, 1'b0);
        cyc(1, 7'b1111111, 0);
        expect_all("ill_dec", 4'(ST_DECODE), c_dec, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 7'b1111111, 1);
            expect_all($sformatf("ill_trap%0d", i), 4'(ST_TRAP), c_none, 1'b1, 1'b0);
        end
        do_reset();

        // JAL opcode
        cyc(1, OP_JAL, 0);
        expect_all("jal_fetch", 4'(ST_FETCH), c_frdy, 1'b0, 1'b0);
        cyc(1, OP_JAL, 0);
        expect_all("jal_dec", 4'(ST_DECODE), c_dec, 1'b0, 1'b0);
        cyc(1, OP_JAL, 0);
`ifdef RV_JAL_EN
        expect_all("jal_exec", 4'(ST_JAL), c_jal, 1'b0, 1'b0);
`else
        expect_all("jal_trap", 4'(ST_TRAP), c_none, 1'b1, 1'b0);
        do_reset();
`endif

        // Reset mid-store drops mem_write immediately.
        cyc(1, OP_STORE, 0);
        expect_all("mid_fetch", 4'(ST_FETCH), c_frdy, 1'b0, 1'b0);
        cyc(1, OP_STORE, 0);
        expect_all("mid_dec", 4'(ST_DECODE), c_dec, 1'b0, 1'b0);
        cyc(1, OP_STORE, 0);
        expect_all("mid_addr", 4'(ST_MEM_ADDR), c_mad, 1'b0, 1'b0);
        cyc(0, OP_STORE, 0);
        expect_all("mid_write", 4'(ST_MEM_WRITE), c_mwr, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        expect_all("mid_reset", 4'(ST_RESET), c_none, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1, OP_R, 0);
        expect_all("post_fetch", 4'(ST_FETCH), c_frdy, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
